addnb_seq: RTL and testbench
============================

ADDNB_SEQ -- requirements
Module: addnb_seq

Interface
REQ-001 SHALL have parameter W, default 8, total operand width in bits.
REQ-002 SHALL have parameter C, default 2, chunk width added per cycle; W SHALL be an integer multiple of C, N = W/C.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-006 x  input  W  operand A, captured when start is accepted.
REQ-007 y  input  W  operand B, captured when start is accepted.
REQ-008 ci  input  1  carry-in, captured when start is accepted.
REQ-009 sub  input  1  subtract select, captured with operands; present only with ADDNB_SUB_EN.
REQ-010 z  output  W  registered sum.
REQ-011 co  output  1  registered carry-out of bit W-1.
REQ-012 ovf  output  1  registered signed overflow = carry into bit W-1 XOR co.
REQ-013 busy  output  1  high while an addition is in progress.
REQ-014 done  output  1  one-cycle pulse marking z/co/ovf updated.

Function
REQ-015 SHALL implement an FSM with states IDLE and RUN, plus a chunk counter of ceil(log2 N) bits (minimum 1 bit).
REQ-016 IDLE, start=1 at edge E0: capture x, y, ci; carry register = ci; counter = 0; go to RUN; busy=1 after E0.
REQ-017 IDLE, start=0: no state change; z/co/ovf hold.
REQ-018 RUN, edge E(k+1), k=0..N-1: add chunk k (bits k*C+C-1..k*C) of captured x and y plus carry register; store the C-bit sum into internal result chunk k; carry register = chunk carry-out; counter increments.
REQ-019 At edge EN (last chunk): z = full internal result, co = final carry, ovf per REQ-012, done=1, busy=0, state = IDLE.
REQ-020 done SHALL be high for exactly one cycle (between EN and E(N+1)); latency from start-sampling edge to done = N cycles.
REQ-021 z/co/ovf SHALL change only at EN and hold until the next completion or reset; intermediate chunk results are never visible on z.
REQ-022 start while busy=1 SHALL be ignored, with no effect on operands or result.
REQ-023 start=1 in the cycle done=1 (state IDLE) SHALL be accepted, giving back-to-back operations every N cycles.
REQ-024 x, y, ci, sub changes after E0 SHALL not affect the operation in progress.
REQ-025 Arithmetic is modulo 2^W; carry out of bit W-1 goes only to co.
REQ-026 C = W SHALL give N = 1: done one cycle after start.

Reset
REQ-027 rst_b=0 at a rising edge SHALL force IDLE, counter=0, carry=0, z=0, co=0, ovf=0, busy=0, done=0, regardless of state.
REQ-028 Reset during RUN SHALL abort the operation; no done pulse is produced for it.
REQ-029 start sampled in the same edge as rst_b=0 SHALL be ignored.

Configuration
REQ-030 Macro ADDNB_SUB_EN defined: sub port present; on capture, y is stored as y XOR {W{sub}} and carry register as ci XOR sub, so sub=1, ci=0 yields x - y; co=1 means no borrow.
REQ-031 ADDNB_SUB_EN undefined: no sub port; block is add-only; behaviour identical to sub=0.

Verification (W=8, C=2, N=4 unless stated)
REQ-032 x=8'h25, y=8'h13, ci=0, start pulse at E0 -> busy=1 for 4 cycles; done=1 after E4 with z=8'h38, co=0, ovf=0.
REQ-033 x=8'hFF, y=8'h01, ci=0 -> z=8'h00, co=1, ovf=0; x=8'h7F, y=8'h01, ci=1 -> z=8'h81, co=0, ovf=1.
REQ-034 Second start pulse at E2 with different operands -> ignored; first result delivered unchanged at E4; start held in done cycle -> next done exactly 4 cycles later.
REQ-035 rst_b=0 at E2 of an operation -> after reset all outputs 0, no done pulse; new start after release completes normally.
REQ-036 ADDNB_SUB_EN: x=8'h10, y=8'h20, sub=1, ci=0 -> z=8'hF0, co=0; x=8'h20, y=8'h10 -> z=8'h10, co=1.
REQ-037 W=8, C=8 -> x=8'hAA, y=8'h55, ci=1 -> done one cycle after start, z=8'h00, co=1.

Source files
------------

// File: rtl/addnb_seq.sv
// addnb_seq: multi-cycle W-bit adder processing C bits per clock (N = W/C cycles per add).
// Optional subtract mode is enabled by defining ADDNB_SUB_EN (adds the sub port).
`default_nettype none

module addnb_seq #(
  parameter int W = 8,
  parameter int C = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
`ifdef ADDNB_SUB_EN
  input  logic         sub,
`endif
  output logic [W-1:0] z,
  output logic         co,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int N  = W / C;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   xa;
  logic [W-1:0]   yb;
  logic [W-1:0]   res;
  logic [W-1:0]   res_nx;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [C:0]     csum;
  logic           last;
  logic           accept;
  logic           cin_msb;
  logic [W-1:0]   y_in;
  logic           c_in;

`ifdef ADDNB_SUB_EN
  // Two's-complement subtract: invert B and fold the +1 into the carry-in.
  assign y_in = y ^ {W{sub}};
  assign c_in = ci ^ sub;
`else
  assign y_in = y;
  assign c_in = ci;
`endif

  // Operands shift right each cycle, so chunk k always sits in the low C bits.
  assign csum    = {1'b0, xa[C-1:0]} + {1'b0, yb[C-1:0]} + {{C{1'b0}}, carry};
  assign res_nx  = (res >> C) | (W'(csum[C-1:0]) << (W - C));
  assign cin_msb = csum[C-1] ^ xa[C-1] ^ yb[C-1];
  assign last    = (cnt == CW'(N - 1));
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      xa    <= '0;
      yb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      z     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        xa    <= x;
        yb    <= y_in;
        carry <= c_in;
        cnt   <= '0;
        res   <= '0;
      end else if (state == RUN) begin
        xa    <= xa >> C;
        yb    <= yb >> C;
        carry <= csum[C];
        res   <= res_nx;
        cnt   <= cnt + 1'b1;
        if (last) begin
          z    <= res_nx;
          co   <= csum[C];
          ovf  <= cin_msb ^ csum[C];
          done <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addnb_seq.sv
// Scoreboard bench for addnb_seq: a W=8/C=2 instance and a W=8/C=8 (single-cycle) instance.
`default_nettype none

module tb_addnb_seq;

  localparam int NA = 4;
  localparam int NB = 1;

  typedef struct {
    logic [7:0] z;
    logic       co;
    logic       ovf;
    int         dcyc;
  } exp_t;

  logic       clk;
  logic       rst_b;
  logic       start_a, ci_a;
  logic [7:0] x_a, y_a;
  logic       start_b, ci_b;
  logic [7:0] x_b, y_b;
  logic [7:0] z_a, z_b;
  logic       co_a, ovf_a, busy_a, done_a;
  logic       co_b, ovf_b, busy_b, done_b;
`ifdef ADDNB_SUB_EN
  logic       sub_a, sub_b;
`endif

  exp_t qa[$];
  exp_t qb[$];
  int   cyc;
  int   pass_cnt;
  int   tot_cnt;
  int   rst_req;
  int   rst_seen;

  addnb_seq #(.W(8), .C(2)) dut_a (
    .clk(clk), .rst_b(rst_b), .start(start_a), .x(x_a), .y(y_a), .ci(ci_a),
`ifdef ADDNB_SUB_EN
    .sub(sub_a),
`endif
    .z(z_a), .co(co_a), .ovf(ovf_a), .busy(busy_a), .done(done_a)
  );

  addnb_seq #(.W(8), .C(8)) dut_b (
    .clk(clk), .rst_b(rst_b), .start(start_b), .x(x_b), .y(y_b), .ci(ci_b),
`ifdef ADDNB_SUB_EN
    .sub(sub_b),
`endif
    .z(z_b), .co(co_b), .ovf(ovf_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: all comparisons happen here, at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_req != rst_seen) begin
      rst_seen = rst_req;
      check("rst_z",    int'(z_a),    0);
      check("rst_co",   int'(co_a),   0);
      check("rst_ovf",  int'(ovf_a),  0);
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_z_b",  int'(z_b),    0);
    end
    if (qa.size() > 0)
      check("a_busy", int'(busy_a), int'(cyc >= qa[0].dcyc - NA && cyc < qa[0].dcyc));
    if (qa.size() > 0 && cyc > qa[0].dcyc) begin
      check("a_timeout", cyc, qa[0].dcyc);
      void'(qa.pop_front());
    end
    if (done_a) begin
      if (qa.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_latency", cyc, e.dcyc);
        check("a_z", int'(z_a), int'(e.z));
        check("a_co", int'(co_a), int'(e.co));
        check("a_ovf", int'(ovf_a), int'(e.ovf));
      end
    end
    if (qb.size() > 0 && cyc > qb[0].dcyc) begin
      check("b_timeout", cyc, qb[0].dcyc);
      void'(qb.pop_front());
    end
    if (done_b) begin
      if (qb.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_latency", cyc, e.dcyc);
        check("b_z", int'(z_b), int'(e.z));
        check("b_co", int'(co_b), int'(e.co));
        check("b_ovf", int'(ovf_b), int'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op on instance A sampled at the next edge, then waits until its done cycle.
  task automatic op_a(input logic [7:0] xv, input logic [7:0] yv, input logic cv,
                      input logic sv, input logic [7:0] ez, input logic eco, input logic eovf);
    exp_t e;
    x_a = xv; y_a = yv; ci_a = cv; start_a = 1'b1;
`ifdef ADDNB_SUB_EN
    sub_a = sv;
`else
    if (sv) $display("note: sub requested without ADDNB_SUB_EN");
`endif
    e.z = ez; e.co = eco; e.ovf = eovf; e.dcyc = cyc + 1 + NA;
    qa.push_back(e);
    tick();
    start_a = 1'b0;
    x_a = 8'h5A; y_a = 8'hC3; ci_a = ~cv;
    repeat (NA) tick();
  endtask

  task automatic op_b(input logic [7:0] xv, input logic [7:0] yv, input logic cv,
                      input logic [7:0] ez, input logic eco, input logic eovf);
    exp_t e;
    x_b = xv; y_b = yv; ci_b = cv; start_b = 1'b1;
    e.z = ez; e.co = eco; e.ovf = eovf; e.dcyc = cyc + 1 + NB;
    qb.push_back(e);
    tick();
    start_b = 1'b0;
    x_b = 8'h00; y_b = 8'h00; ci_b = 1'b0;
    repeat (NB) tick();
  endtask

  initial begin
    pass_cnt = 0; tot_cnt = 0; rst_req = 0; rst_seen = 0;
    rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    x_a = '0; y_a = '0; ci_a = 1'b0; x_b = '0; y_b = '0; ci_b = 1'b0;
`ifdef ADDNB_SUB_EN
    sub_a = 1'b0; sub_b = 1'b0;
`endif
    repeat (3) tick();
    rst_req++;
    rst_b = 1'b1;
    tick();

    // Basic additions, carry and overflow corners
    op_a(8'h25, 8'h13, 1'b0, 1'b0, 8'h38, 1'b0, 1'b0);
    op_a(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op_a(8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
    op_a(8'h3C, 8'hA5, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b0);

    // Start during busy is ignored; start held into the done cycle is accepted
    begin
      exp_t e;
      x_a = 8'h40; y_a = 8'h40; ci_a = 1'b0; start_a = 1'b1;
      e.z = 8'h80; e.co = 1'b0; e.ovf = 1'b1; e.dcyc = cyc + 1 + NA;
      qa.push_back(e);
      tick();                                   // E0
      start_a = 1'b0;
      tick();                                   // E1
      x_a = 8'h11; y_a = 8'h22; ci_a = 1'b1; start_a = 1'b1;
      tick(); tick(); tick();                   // E2..E4 ignored
      x_a = 8'h0F; y_a = 8'hF1; ci_a = 1'b0;
      e.z = 8'h00; e.co = 1'b1; e.ovf = 1'b0; e.dcyc = cyc + 1 + NA;
      qa.push_back(e);
      tick();                                   // E5 accepts
      start_a = 1'b0;
      repeat (NA) tick();
    end

    // Reset in the middle of an operation aborts it, start during reset ignored
    x_a = 8'h99; y_a = 8'h99; ci_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    rst_b = 1'b0; start_a = 1'b1;
    tick();
    rst_req++;
    rst_b = 1'b1; start_a = 1'b0;
    repeat (NA + 2) tick();
    op_a(8'h64, 8'h32, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);

`ifdef ADDNB_SUB_EN
    op_a(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    op_a(8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
`endif

    // Single-chunk instance: done one cycle after start
    op_b(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    op_b(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    op_b(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    repeat (NA + 3) tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, tot_cnt);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
